// File: rtl/pixel_stream_proc_if.sv
// RX/TX FIFO bus seen by the pixel processor: FWFT read side and full-flagged write side.
interface pixel_stream_proc_if #(
  parameter int DATA_W = 8
);
  // Handshake: a pop happens on any cycle with rd_uart=1, which is only raised
  // while rx_empty=0 (r_data is then valid). A push happens on any cycle with
  // wr_uart=1, which is only raised while tx_full=0. w_data is held until then.
  logic              rx_empty;
  logic [DATA_W-1:0] r_data;
  logic              rd_uart;
  logic              tx_full;
  logic [DATA_W-1:0] w_data;
  logic              wr_uart;

  modport master (
    input  rx_empty, r_data, tx_full,
    output rd_uart, w_data, wr_uart
  );

  modport slave (
    output rx_empty, r_data, tx_full,
    input  rd_uart, w_data, wr_uart
  );
endinterface

// File: rtl/pixel_stream_proc.sv
// Streams bytes from the RX FIFO through a point operation into the TX FIFO,
// one byte per four-state pass, with per-frame byte and frame counters.
module pixel_stream_proc #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   offset,
  pixel_stream_proc_if.master fifo,
  output logic [DATA_W-1:0]   last_in,
  output logic [CNT_W-1:0]    byte_cnt,
  output logic [7:0]          frame_cnt,
  output logic                frame_done,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_CALC  = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t            state_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;
  logic [DATA_W-1:0] last_in_q;
  logic [CNT_W-1:0]  byte_cnt_q;
  logic [7:0]        frame_cnt_q;
  logic              frame_done_q;
  logic [DATA_W+1:0] sum;

  // Two extra bits: bit DATA_W+1 flags a negative result, bit DATA_W an overflow.
  always_comb begin
    sum    = {2'b00, din_q} + {{2{offset[DATA_W-1]}}, offset};
    dout_d = din_q;
    case (mode)
      2'b00: dout_d = din_q;
      2'b01: begin
        if (sum[DATA_W+1])    dout_d = '0;
        else if (sum[DATA_W]) dout_d = '1;
        else                  dout_d = sum[DATA_W-1:0];
      end
      2'b10: dout_d = ~din_q;
      2'b11: dout_d = (din_q >= offset) ? '1 : '0;
      default: dout_d = din_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      din_q        <= '0;
      dout_q       <= '0;
      last_in_q    <= '0;
      byte_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run && !fifo.rx_empty) state_q <= S_FETCH;
        end
        S_FETCH: begin
          din_q     <= fifo.r_data;
          last_in_q <= fifo.r_data;
          state_q   <= S_CALC;
        end
        S_CALC: begin
          dout_q  <= dout_d;
          state_q <= S_SEND;
        end
        S_SEND: begin
          if (!fifo.tx_full) begin
            state_q <= S_IDLE;
            if (byte_cnt_q == LAST_IDX) begin
              byte_cnt_q   <= '0;
              frame_cnt_q  <= frame_cnt_q + 8'd1;
              frame_done_q <= 1'b1;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo.rd_uart = (state_q == S_FETCH);
  assign fifo.wr_uart = (state_q == S_SEND) && !fifo.tx_full;
  assign fifo.w_data  = dout_q;
  assign last_in      = last_in_q;
  assign byte_cnt     = byte_cnt_q;
  assign frame_cnt    = frame_cnt_q;
  assign frame_done   = frame_done_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/pixel_stream_proc.md
# pixel_stream_proc

Autonomous per-byte pixel processor between the UART receive and transmit FIFOs. When `run` is high it drains bytes from the RX FIFO, applies a selectable point operation (pass, signed saturating offset, invert, threshold), and pushes each result into the TX FIFO. It counts bytes per frame and reports frame completion, replacing button-paced single-byte loopback with streamed image traffic.

## Interface
- `DATA_W`, 8, pixel/byte width.
- `FRAME_LEN`, 16, bytes per frame (≥2).
- `CNT_W`, `$clog2(FRAME_LEN)`, byte counter width.

- `clk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `run` in 1: level enable; sampled in IDLE only.
- `mode` in 2: 00 pass, 01 offset, 10 invert, 11 threshold.
- `offset` in DATA_W: signed offset (mode 01) / unsigned threshold (mode 11).
- `rx_empty` in 1: RX FIFO empty.
- `r_data` in DATA_W: RX FIFO head, valid while `rx_empty`=0 (first-word fall-through).
- `rd_uart` out 1: RX pop strobe.
- `tx_full` in 1: TX FIFO full.
- `w_data` out DATA_W: TX write data.
- `wr_uart` out 1: TX push strobe.
- `last_in` out DATA_W: last byte fetched.
- `byte_cnt` out CNT_W: bytes written in current frame.
- `frame_cnt` out 8: completed frames, wraps 255→0.
- `frame_done` out 1: one-cycle pulse per completed frame.

## Operation
- FSM states: IDLE, FETCH, CALC, SEND.
- IDLE: `run`=1 and `rx_empty`=0 → FETCH; otherwise stay.
- FETCH: `rd_uart`=1 for exactly this cycle; `din`←`r_data`, `last_in`←`r_data`; → CALC.
- CALC: `dout`←f(`din`) using `mode`/`offset` sampled this cycle; → SEND.
- SEND: if `tx_full`=0: `wr_uart`=1, `w_data`=`dout`, → IDLE, byte count update; if `tx_full`=1: hold SEND, `wr_uart`=0, `dout` unchanged.
- f, mode 00: `din`.
- f, mode 01: `din` (unsigned) + `offset` (signed two's complement), computed in DATA_W+2 bits; <0 → 0, >2^DATA_W−1 → 2^DATA_W−1.
- f, mode 10: `~din`.
- f, mode 11: `din` ≥ `offset` (unsigned) → all ones, else 0.
- Byte count: on each write, if `byte_cnt`=FRAME_LEN−1 → `byte_cnt`←0, `frame_cnt`←`frame_cnt`+1, `frame_done`=1 next cycle; else `byte_cnt`+1.
- `run` deasserted mid-byte: byte in flight completes (incl. SEND stall), FSM then waits in IDLE; counters are not cleared.
- `mode`/`offset` changes only affect bytes whose CALC occurs after the change.

## Timing
- `rd_uart`, `wr_uart` are Moore decodes of state (`wr_uart` also gated by `tx_full`); `w_data` = `dout` register, stable throughout SEND.
- Minimum 4 cycles per byte (IDLE→FETCH→CALC→SEND→IDLE); peak 1 byte / 4 clk.
- Latency FETCH cycle → `wr_uart`: 2 cycles when `tx_full`=0.
- `frame_done` asserted the cycle after the final write, for exactly one cycle.
- Never more than one pop per push; no pop while a byte is held in SEND.
- Reset (any state, incl. mid-SEND stall): next cycle state IDLE, `rd_uart`=0, `wr_uart`=0, `w_data`=0, `last_in`=0, `byte_cnt`=0, `frame_cnt`=0, `frame_done`=0; in-flight byte discarded.

## Test plan
- Mode 00, FRAME_LEN=4, push 0x10,0x20,0x30,0x40 with `run`=1 → TX gets same 4 bytes, `frame_done` one pulse, `frame_cnt`=1, `byte_cnt`=0, each byte ≥4 cycles apart.
- Mode 01: `offset`=0x64 on 0x32, 0xC8 → 0x96, 0xFF; `offset`=0x9C (−100) on 0x32, 0xC8 → 0x00, 0x64.
- Modes 10/11: invert 0x5A → 0xA5; threshold `offset`=0x80 on 0x7F, 0x80 → 0x00, 0xFF.
- Hold `tx_full`=1 for 10 cycles during SEND → `wr_uart`=0, no further `rd_uart`, `w_data` stable; release → single write of the correct byte.
- `rx_empty`=0 with `run`=0 → no `rd_uart`; drop `run` during CALC → that byte still written, then idle.
- Assert `reset` mid-frame (`byte_cnt`=2) during SEND stall → all outputs 0 next cycle, no write of the pending byte; subsequent frame counts from 0.
